// File: rtl/sram_dual_bank_arbiter_pkg.sv
// rtl/sram_dual_bank_arbiter_pkg.sv - shared types and widths for the dual-bank SRAM arbiter
package sram_dual_bank_arbiter_pkg;

  localparam int ADDR_W   = 20;
  localparam int BANK_BIT = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_dual_bank_arbiter_rr.sv
// rtl/sram_dual_bank_arbiter_rr.sv - two-way grant logic with last-grant memory and B-priority override
module sram_dual_bank_arbiter_rr #(
  parameter int PRIO_B = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_req,
  input  logic b_req,
  input  logic update,
  output logic grant_b
);

  logic last_b;

  // On a tie the port that did not win last time goes next, unless B is forced to win.
  always_comb begin
    grant_b = 1'b0;
    if (a_req && b_req) begin
      grant_b = (PRIO_B != 0) ? 1'b1 : ~last_b;
    end else if (b_req) begin
      grant_b = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b <= 1'b1;
    end else if (update && (a_req || b_req)) begin
      last_b <= grant_b;
    end
  end

endmodule

// File: rtl/sram_dual_bank_arbiter.sv
// rtl/sram_dual_bank_arbiter.sv - shares two async 512KB x8 SRAM banks between ports A and B
module sram_dual_bank_arbiter
  import sram_dual_bank_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int PRIO_B        = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [18:0]       sram_a,
  output logic              sram0_we_n,
  output logic              sram1_we_n,
  output logic [7:0]        sram0_d_out,
  output logic [7:0]        sram1_d_out,
  output logic              sram0_d_oe,
  output logic              sram1_d_oe,
  input  logic [7:0]        sram0_d_in,
  input  logic [7:0]        sram1_d_in
);

  localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              we;
  logic              bank;
  logic              gnt_b;
  logic              grant_b;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [7:0]        sel_wdata;

  sram_dual_bank_arbiter_rr #(
    .PRIO_B(PRIO_B)
  ) u_rr (
    .clk    (clk),
    .reset_n(reset_n),
    .a_req  (a_req),
    .b_req  (b_req),
    .update (state == ST_IDLE),
    .grant_b(grant_b)
  );

  always_comb begin
    sel_addr  = a_addr;
    sel_we    = a_we;
    sel_wdata = a_wdata;
    if (grant_b) begin
      sel_addr  = b_addr;
      sel_we    = b_we;
      sel_wdata = b_wdata;
    end
  end

  // Every pin is registered; each state's pin values are loaded on the edge that enters it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      we          <= 1'b0;
      bank        <= 1'b0;
      gnt_b       <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      rdata       <= 8'h00;
      busy        <= 1'b0;
      sram_a      <= 19'd0;
      sram0_we_n  <= 1'b1;
      sram1_we_n  <= 1'b1;
      sram0_d_out <= 8'h00;
      sram1_d_out <= 8'h00;
      sram0_d_oe  <= 1'b0;
      sram1_d_oe  <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            state  <= ST_SETUP;
            busy   <= 1'b1;
            gnt_b  <= grant_b;
            we     <= sel_we;
            bank   <= sel_addr[BANK_BIT];
            sram_a <= sel_addr[BANK_BIT-1:0];
            if (sel_we) begin
              if (sel_addr[BANK_BIT]) begin
                sram1_d_out <= sel_wdata;
                sram1_d_oe  <= 1'b1;
              end else begin
                sram0_d_out <= sel_wdata;
                sram0_d_oe  <= 1'b1;
              end
            end
          end
        end
        ST_SETUP: begin
          state <= ST_STROBE;
          cnt   <= STROBE_LAST;
          if (we) begin
            if (bank) sram1_we_n <= 1'b0;
            else      sram0_we_n <= 1'b0;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            state      <= ST_HOLD;
            sram0_we_n <= 1'b1;
            sram1_we_n <= 1'b1;
            if (!we) rdata <= bank ? sram1_d_in : sram0_d_in;
            if (gnt_b) b_ack <= 1'b1;
            else       a_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          sram0_d_oe <= 1'b0;
          sram1_d_oe <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_dual_bank_arbiter.sv
// tb/tb_sram_dual_bank_arbiter.sv - scoreboard bench: two DUTs (round-robin and B-priority) on SRAM models
module tb_sram_dual_bank_arbiter;

  typedef struct packed {
    logic        w;
    logic [19:0] ad;
    logic [7:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0]       a_req, a_we, a_ack, b_req, b_we, b_ack, busy;
  logic [1:0][19:0] a_addr, b_addr;
  logic [1:0][7:0]  a_wdata, b_wdata, rdata;
  logic [1:0][18:0] sram_a;
  logic [1:0]       s0_we_n, s1_we_n, s0_oe, s1_oe;
  logic [1:0][7:0]  s0_d_out, s1_d_out, s0_d_in, s1_d_in;

  logic [7:0] mem [int];
  logic [7:0] ref_mem [int];
  exp_t       exp_q [4][$];
  int         order_q [2][$];
  int         lo0 [2], lo1 [2], oe_hi [2];
  logic [18:0] strobe_a [2];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_dual_bank_arbiter #(
      .ACCESS_CYCLES(2),
      .PRIO_B       (g)
    ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .a_req      (a_req[g]),
      .a_addr     (a_addr[g]),
      .a_we       (a_we[g]),
      .a_wdata    (a_wdata[g]),
      .a_ack      (a_ack[g]),
      .b_req      (b_req[g]),
      .b_addr     (b_addr[g]),
      .b_we       (b_we[g]),
      .b_wdata    (b_wdata[g]),
      .b_ack      (b_ack[g]),
      .rdata      (rdata[g]),
      .busy       (busy[g]),
      .sram_a     (sram_a[g]),
      .sram0_we_n (s0_we_n[g]),
      .sram1_we_n (s1_we_n[g]),
      .sram0_d_out(s0_d_out[g]),
      .sram1_d_out(s1_d_out[g]),
      .sram0_d_oe (s0_oe[g]),
      .sram1_d_oe (s1_oe[g]),
      .sram0_d_in (s0_d_in[g]),
      .sram1_d_in (s1_d_in[g])
    );
  end

  function automatic int key(input int inst, input logic [19:0] ad);
    return (inst << 20) | int'(ad);
  endfunction

  function automatic logic [7:0] mem_rd(input int k);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin-level SRAM model plus bus-exclusivity checks, evaluated on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!s0_we_n[i]) begin
        mem[key(i, {1'b0, sram_a[i]})] = s0_d_out[i];
        lo0[i]++;
        strobe_a[i] = sram_a[i];
        check_eq("we0_with_oe0", 32'(s0_oe[i]), 32'd1);
      end
      if (!s1_we_n[i]) begin
        mem[key(i, {1'b1, sram_a[i]})] = s1_d_out[i];
        lo1[i]++;
        strobe_a[i] = sram_a[i];
        check_eq("we1_with_oe1", 32'(s1_oe[i]), 32'd1);
      end
      if (s0_oe[i] || s1_oe[i] || !s0_we_n[i] || !s1_we_n[i]) begin
        oe_hi[i] += (s0_oe[i] || s1_oe[i]) ? 1 : 0;
        check_eq("one_we", 32'(!s0_we_n[i] && !s1_we_n[i]), 32'd0);
        check_eq("one_oe", 32'(s0_oe[i] && s1_oe[i]), 32'd0);
      end
      s0_d_in[i] = mem_rd(key(i, {1'b0, sram_a[i]}));
      s1_d_in[i] = mem_rd(key(i, {1'b1, sram_a[i]}));
    end
  end

  task automatic drive(input int inst, input int port, input logic req, input logic [19:0] ad,
                       input logic w, input logic [7:0] d);
    if (port == 0) begin
      a_req[inst] = req; a_addr[inst] = ad; a_we[inst] = w; a_wdata[inst] = d;
    end else begin
      b_req[inst] = req; b_addr[inst] = ad; b_we[inst] = w; b_wdata[inst] = d;
    end
  endtask

  // Issues n back-to-back accesses, keeping req high between them; lat = negedges to the last ack.
  task automatic run_port(input int inst, input int port, input int n, input logic [19:0] base,
                          input logic w, input logic [7:0] dseed, output int lat);
    int qi;
    qi  = inst * 2 + port;
    lat = 0;
    for (int k = 0; k < n; k++) begin
      logic [19:0] ad;
      logic [7:0]  wd;
      exp_t        e;
      int          cyc;
      logic        got;
      ad = base + 20'(k);
      wd = dseed + 8'(k);
      if (w) ref_mem[key(inst, ad)] = wd;
      e.w  = w;
      e.ad = ad;
      e.d  = ref_mem.exists(key(inst, ad)) ? ref_mem[key(inst, ad)] : 8'h00;
      exp_q[qi].push_back(e);
      drive(inst, port, 1'b1, ad, w, wd);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
        @(negedge clk);
        cyc++;
        got = (port == 0) ? a_ack[inst] : b_ack[inst];
      end
      if (!got) begin
        check_eq("ack_timeout", 32'(got), 32'd1);
        drive(inst, port, 1'b0, ad, w, wd);
        return;
      end
      lat = cyc;
      e = exp_q[qi].pop_front();
      if (e.w) check_eq("wr_mem", 32'(mem_rd(key(inst, e.ad))), 32'(e.d));
      else     check_eq("rdata", 32'(rdata[inst]), 32'(e.d));
      order_q[inst].push_back(port);
      @(negedge clk);
      check_eq("ack_pulse", 32'((port == 0) ? a_ack[inst] : b_ack[inst]), 32'd0);
      if (k == n - 1) drive(inst, port, 1'b0, ad, w, wd);
    end
  endtask

  initial begin
    int lat, lat_a, lat_b, waited, acks;
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b0, 20'd0, 1'b0, 8'h00);
      drive(i, 1, 1'b0, 20'd0, 1'b0, 8'h00);
      lo0[i] = 0; lo1[i] = 0; oe_hi[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_ctrl", 32'({a_ack[i], b_ack[i], busy[i], s0_we_n[i], s1_we_n[i], s0_oe[i], s1_oe[i]}),
               32'b0001100);
      check_eq("rst_bus", 32'({sram_a[i], rdata[i]}), 32'd0);
      check_eq("rst_dout", 32'({s0_d_out[i], s1_d_out[i]}), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single A write to bank 0
    lo0[0] = 0; lo1[0] = 0;
    run_port(0, 0, 1, 20'h00010, 1'b1, 8'h5A, lat);
    check_eq("t1_latency", 32'(lat), 32'd4);
    check_eq("t1_we0_low", 32'(lo0[0]), 32'd2);
    check_eq("t1_we1_low", 32'(lo1[0]), 32'd0);
    check_eq("t1_sram_a", 32'(strobe_a[0]), 32'h00010);

    // 2: B read from bank 1
    mem[key(0, 20'h80010)] = 8'hC3;
    ref_mem[key(0, 20'h80010)] = 8'hC3;
    oe_hi[0] = 0;
    run_port(0, 1, 1, 20'h80010, 1'b0, 8'h00, lat);
    check_eq("t2_latency", 32'(lat), 32'd4);
    check_eq("t2_no_oe", 32'(oe_hi[0]), 32'd0);

    // 3 and 4: simultaneous contention, round-robin on DUT 0 and B-priority on DUT 1
    for (int i = 0; i < 2; i++) begin
      order_q[i].delete();
      for (int k = 0; k < 4; k++) begin
        mem[key(i, 20'h80100 + 20'(k))] = 8'h60 + 8'(k);
        ref_mem[key(i, 20'h80100 + 20'(k))] = 8'h60 + 8'(k);
      end
    end
    fork
      run_port(0, 0, 4, 20'h00100, 1'b1, 8'hA0, lat_a);
      run_port(0, 1, 4, 20'h80100, 1'b0, 8'h00, lat_b);
      run_port(1, 0, 4, 20'h00200, 1'b1, 8'hD0, lat);
      run_port(1, 1, 4, 20'h80100, 1'b0, 8'h00, waited);
    join
    check_eq("t3_count", 32'(order_q[0].size()), 32'd8);
    for (int k = 0; k < 8 && k < order_q[0].size(); k++)
      check_eq("t3_order", 32'(order_q[0][k]), 32'(k % 2));
    check_eq("t4_count", 32'(order_q[1].size()), 32'd8);
    for (int k = 0; k < 8 && k < order_q[1].size(); k++)
      check_eq("t4_order", 32'(order_q[1][k]), (k < 4) ? 32'd1 : 32'd0);

    // 5: reset during the strobe of a bank-1 write
    drive(0, 0, 1'b1, 20'h80020, 1'b1, 8'h77);
    waited = 0;
    while (s1_we_n[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t5_strobe_seen", 32'(s1_we_n[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("t5_we_n", 32'({s0_we_n[0], s1_we_n[0]}), 32'b11);
    check_eq("t5_oe", 32'({s0_oe[0], s1_oe[0]}), 32'd0);
    check_eq("t5_busy", 32'(busy[0]), 32'd0);
    drive(0, 0, 1'b0, 20'h80020, 1'b1, 8'h77);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += (a_ack[0] || b_ack[0]) ? 1 : 0;
    end
    check_eq("t5_no_ack", 32'(acks), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    run_port(0, 0, 1, 20'h80030, 1'b1, 8'h44, lat);
    check_eq("t5_after_latency", 32'(lat), 32'd4);
    run_port(0, 0, 1, 20'h80030, 1'b0, 8'h00, lat);

    // 6: bank boundary
    run_port(0, 0, 1, 20'h7FFFF, 1'b1, 8'h11, lat);
    run_port(0, 1, 1, 20'h80000, 1'b1, 8'h22, lat);
    check_eq("t6_bank0_row", 32'(mem_rd(key(0, 20'h7FFFF))), 32'h11);
    check_eq("t6_bank1_row", 32'(mem_rd(key(0, 20'h80000))), 32'h22);
    run_port(0, 0, 1, 20'h7FFFF, 1'b0, 8'h00, lat);
    run_port(0, 1, 1, 20'h80000, 1'b0, 8'h00, lat);
    check_eq("t6_last_rdata", 32'(rdata[0]), 32'h22);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
